marker_serializer: RTL

//  Transmit end of the 4-bit sync-marker link: frames each accepted parallel word
//  as a serial burst (MARKER then DATA, MSB first) on one line. The receive side

---
 rtl/marker_serializer_pkg.sv | 9 +
 rtl/piso_shreg.sv | 19 +
 rtl/marker_serializer.sv | 54 +++++
 3 files changed

// File: rtl/marker_serializer_pkg.sv
// marker_serializer_pkg: sync-marker constants shared with the receive-side detector, plus the FSM state encodings.
package marker_serializer_pkg;
    localparam int MARKER_W = 4;
    localparam logic [MARKER_W-1:0] MARKER = 4'b0111;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load, shift-left register with zero fill that exposes its MSB.
module piso_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {q[WIDTH-2:0], 1'b0};
    end
    assign msb = q[WIDTH-1];
endmodule

// File: rtl/marker_serializer.sv
// marker_serializer: frames each accepted word as MARKER then DATA, MSB first, on one serial line.
module marker_serializer
    import marker_serializer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);
    localparam int FW = MARKER_W + DATA_W;
    localparam int CW = $clog2(FW);
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic busy, accept, last, msb;

    // abort outranks a same-cycle handshake and also masks the final-bit pulse
    always_comb begin
        busy = state == ST_SEND;
        in_ready = state == ST_IDLE;
        accept = in_valid && in_ready && !abort;
        last = busy && cnt == '0;
        tx_active = busy;
        tx_bit = busy && msb;
        frame_done = last && !abort;
        state_nxt = busy ? ((abort || last) ? ST_IDLE : ST_SEND) : (accept ? ST_SEND : ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= accept ? CW'(FW - 1) : (busy && abort) ? '0 : (busy && cnt != '0) ? cnt - CW'(1) : cnt;
        end
    end

    // an abort reuses the load path with zero data to clear the frame in flight
    piso_shreg #(.WIDTH(FW)) u_shreg (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept || (busy && abort)),
        .shift(busy),
        .d    (accept ? {MARKER, in_data} : {FW{1'b0}}),
        .msb  (msb)
    );
endmodule
